// File: rtl/recorder_pkg.sv
// Shared definitions for the recorder transport path: mode encoding, default
// geometry and the speed-factor sanitiser.
package recorder_pkg;

   localparam int unsigned DEFAULT_ADDR_W      = 18;
   localparam int unsigned DEFAULT_SAMPLE_RATE = 8000;
   localparam int unsigned DEFAULT_SPD_W       = 4;

   // Largest speed factor honoured; anything else falls back to 1.
   localparam int unsigned MAX_FACTOR = 8;

   typedef enum logic [1:0] {
      MODE_IDLE   = 2'd0,
      MODE_RECORD = 2'd1,
      MODE_PLAY   = 2'd2,
      MODE_PAUSE  = 2'd3
   } mode_e;

   // Effective speed factor: 0 or anything above MAX_FACTOR behaves as 1.
   function automatic int unsigned eff_factor(input int unsigned f);
      return (f == 0 || f > MAX_FACTOR) ? 1 : f;
   endfunction

endpackage

// File: rtl/bcd_sec_counter.sv
// Elapsed-seconds counter in BCD. Accumulates address steps and rolls one
// second every SAMPLE_RATE samples; tens wrap 9 -> 0.
module bcd_sec_counter #(
   parameter int unsigned SAMPLE_RATE = 8000,
   parameter int unsigned STEP_W      = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              advance,
   input  logic [STEP_W-1:0] step,
   output logic [3:0]        sec_tens,
   output logic [3:0]        sec_ones
);

   // Holds residual samples below one second plus one maximal step.
   localparam int unsigned ACC_W = $clog2(SAMPLE_RATE + (1 << STEP_W));

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_sum;
   logic             wrap;

   // Next accumulator value and whether it completes a second.
   always_comb begin
      acc_sum = acc + ACC_W'(step);
      wrap    = (acc_sum >= ACC_W'(SAMPLE_RATE));
   end

   // Sample accumulator and BCD digits; clear tracks every address reset.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         acc      <= '0;
         sec_ones <= 4'd0;
         sec_tens <= 4'd0;
      end else if (advance) begin
         if (wrap) begin
            acc <= acc_sum - ACC_W'(SAMPLE_RATE);
            if (sec_ones == 4'd9) begin
               sec_ones <= 4'd0;
               sec_tens <= (sec_tens == 4'd9) ? 4'd0 : sec_tens + 4'd1;
            end else begin
               sec_ones <= sec_ones + 4'd1;
            end
         end else begin
            acc <= acc_sum;
         end
      end
   end

endmodule

// File: rtl/transport_ctrl.sv
// Transport controller: turns play/record/stop levels into the recorder mode,
// owns the single SRAM sample address, record length, fast/slow stepping and
// the elapsed-seconds display count.
module transport_ctrl
   import recorder_pkg::*;
#(
   parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
   parameter int unsigned SAMPLE_RATE = DEFAULT_SAMPLE_RATE,
   parameter int unsigned SPD_W       = DEFAULT_SPD_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play,
   input  logic              record,
   input  logic              stop,
   input  logic              sample_tick,
   input  logic              speed,
   input  logic [SPD_W-1:0]  factor,
   output logic [1:0]        mode,
   output logic [ADDR_W-1:0] addr,
   output logic              wr_en,
   output logic              rd_en,
   output logic [SPD_W-1:0]  slow_phase,
   output logic [ADDR_W-1:0] end_addr,
   output logic [3:0]        sec_tens,
   output logic [3:0]        sec_ones
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   mode_e             state;
   logic              play_q;
   logic              record_q;
   logic              stop_q;
   logic              stop_edge;
   logic              record_edge;
   logic              play_edge;
   logic [SPD_W-1:0]  eff_n;
   logic [SPD_W-1:0]  step_n_q;   // factor captured at the tick that issued rd_en
   logic              slow_q;     // speed captured at the same tick
   logic [SPD_W-1:0]  adv_step;
   logic [SPD_W-1:0]  phase_after;
   logic [ADDR_W:0]   adv_sum;
   logic              last_phase;
   logic              adv_now;
   logic              rec_full;
   logic              play_done;
   logic              force_zero;
   logic              sec_adv;

   assign mode = state;

   // Previous button levels for rising-edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         play_q   <= 1'b0;
         record_q <= 1'b0;
         stop_q   <= 1'b0;
      end else begin
         play_q   <= play;
         record_q <= record;
         stop_q   <= stop;
      end
   end

   // Resolve edge priority and decode this cycle's address advance/termination.
   always_comb begin
      stop_edge   = stop & ~stop_q;
      record_edge = record & ~record_q & ~stop_edge;
      play_edge   = play & ~play_q & ~stop_edge & ~(record & ~record_q);
      eff_n       = SPD_W'(eff_factor(32'(factor)));
      adv_step    = (state == MODE_PLAY && !slow_q) ? step_n_q : SPD_W'(1);
      // One extra bit so a step past the top of memory still compares correctly.
      adv_sum     = {1'b0, addr} + {{(ADDR_W + 1 - SPD_W){1'b0}}, adv_step};
      last_phase  = (slow_phase == step_n_q - SPD_W'(1));
      phase_after = slow_phase;
      adv_now     = 1'b0;
      rec_full    = 1'b0;
      play_done   = 1'b0;
      force_zero  = 1'b0;
      unique case (state)
         MODE_IDLE: begin
            force_zero = record_edge | (play_edge & (end_addr != '0));
         end
         MODE_RECORD: begin
            // The strobe cycle is when the write lands; advance once it has.
            if (!stop_edge && wr_en) begin
               adv_now  = 1'b1;
               rec_full = (addr == ADDR_MAX);
            end
            force_zero = stop_edge | rec_full;
         end
         MODE_PLAY: begin
            if (!stop_edge && rd_en) begin
               if (slow_q) begin
                  phase_after = last_phase ? '0 : slow_phase + SPD_W'(1);
                  adv_now     = last_phase;
               end else begin
                  adv_now = 1'b1;
               end
               play_done = adv_now && (adv_sum >= {1'b0, end_addr});
            end
            force_zero = play_done;
         end
         MODE_PAUSE: begin
            force_zero = stop_edge | record_edge;
         end
      endcase
      sec_adv = adv_now & ~force_zero;
   end

   // Mode FSM with registered strobes, address, phase and record length.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= MODE_IDLE;
         addr       <= '0;
         end_addr   <= '0;
         wr_en      <= 1'b0;
         rd_en      <= 1'b0;
         slow_phase <= '0;
         step_n_q   <= SPD_W'(1);
         slow_q     <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         rd_en <= 1'b0;
         if (force_zero) begin
            addr       <= '0;
            slow_phase <= '0;
         end else if (adv_now) begin
            addr <= adv_sum[ADDR_W-1:0];
         end
         unique case (state)
            MODE_IDLE: begin
               if (record_edge) begin
                  state <= MODE_RECORD;
               end else if (play_edge && end_addr != '0) begin
                  state <= MODE_PLAY;
               end
            end
            MODE_RECORD: begin
               if (stop_edge) begin
                  state    <= MODE_IDLE;
                  end_addr <= addr;
               end else if (rec_full) begin
                  // Length saturates: the top word is recorded but not addressable +1.
                  state    <= MODE_IDLE;
                  end_addr <= ADDR_MAX;
               end else if (sample_tick) begin
                  wr_en <= 1'b1;
               end
            end
            MODE_PLAY: begin
               if (stop_edge) begin
                  state <= MODE_PAUSE;
               end else if (play_done) begin
                  state <= MODE_IDLE;
               end else if (sample_tick) begin
                  rd_en      <= 1'b1;
                  step_n_q   <= eff_n;
                  slow_q     <= ~speed;
                  slow_phase <= (phase_after >= eff_n) ? '0 : phase_after;
               end else begin
                  slow_phase <= phase_after;
               end
            end
            MODE_PAUSE: begin
               if (stop_edge) begin
                  state <= MODE_IDLE;
               end else if (record_edge) begin
                  state <= MODE_RECORD;
               end else if (play_edge) begin
                  state <= MODE_PLAY;
               end
            end
         endcase
      end
   end

   bcd_sec_counter #(
      .SAMPLE_RATE (SAMPLE_RATE),
      .STEP_W      (SPD_W)
   ) u_sec (
      .clk      (clk),
      .reset    (reset),
      .clear    (force_zero),
      .advance  (sec_adv),
      .step     (adv_step),
      .sec_tens (sec_tens),
      .sec_ones (sec_ones)
   );

endmodule
